// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline hazard inputs from D/E/M/W and the
// stall/flush/forward controls plus debug counters going back to the core.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
   logic             trigger;
   logic [4:0]       Rs1D_i;
   logic [4:0]       Rs2D_i;
   logic [4:0]       Rs1E_i;
   logic [4:0]       Rs2E_i;
   logic [4:0]       RdE_i;
   logic [1:0]       ResultSrcE_i;
   logic [1:0]       PCSrcE_i;
   logic [4:0]       RdM_i;
   logic             RegWriteM_i;
   logic [4:0]       RdW_i;
   logic             RegWriteW_i;
   logic             StallF_o;
   logic             StallD_o;
   logic             FlushD_o;
   logic             FlushE_o;
   logic [1:0]       ForwardAE_o;
   logic [1:0]       ForwardBE_o;
   logic             Running_o;
   logic [CNT_W-1:0] StallCnt_o;
   logic [CNT_W-1:0] FlushCnt_o;

   modport slave (
      input  trigger, Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, ResultSrcE_i,
             PCSrcE_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i,
      output StallF_o, StallD_o, FlushD_o, FlushE_o, ForwardAE_o,
             ForwardBE_o, Running_o, StallCnt_o, FlushCnt_o
   );

   modport master (
      output trigger, Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, ResultSrcE_i,
             PCSrcE_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i,
      input  StallF_o, StallD_o, FlushD_o, FlushE_o, ForwardAE_o,
             ForwardBE_o, Running_o, StallCnt_o, FlushCnt_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: IDLE/RUN start-up gate, load-use stall,
// redirect flush, E-stage forwarding select and saturating event counters.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             active;
   logic             lw_stall;
   logic             redir;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic       we_m,
                                          input logic [4:0] rd_w,
                                          input logic       we_w);
      if (we_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
      else if (we_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
      else                                         return 2'b00;
   endfunction

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state == IDLE && bus.trigger) state_nx = RUN;
   end

   // Hazard logic is masked while rst is high so outputs show IDLE values during reset.
   assign active   = (state == RUN) && !rst;
   assign lw_stall = (bus.ResultSrcE_i == 2'b01) && (bus.RdE_i != 5'd0) &&
                     ((bus.RdE_i == bus.Rs1D_i) || (bus.RdE_i == bus.Rs2D_i));
   assign redir    = (bus.PCSrcE_i != 2'b00);

   // NOTE: every output gets a default first, so no path through the block can infer a latch.
   always_comb begin
      bus.StallF_o    = 1'b1;
      bus.StallD_o    = 1'b0;
      bus.FlushD_o    = 1'b1;
      bus.FlushE_o    = 1'b1;
      bus.ForwardAE_o = 2'b00;
      bus.ForwardBE_o = 2'b00;
      if (active) begin
         bus.StallF_o    = lw_stall && !redir;
         bus.StallD_o    = lw_stall && !redir;
         bus.FlushD_o    = redir;
         bus.FlushE_o    = redir || lw_stall;
         bus.ForwardAE_o = fwd_sel(bus.Rs1E_i, bus.RdM_i, bus.RegWriteM_i,
                                   bus.RdW_i, bus.RegWriteW_i);
         bus.ForwardBE_o = fwd_sel(bus.Rs2E_i, bus.RdM_i, bus.RegWriteM_i,
                                   bus.RdW_i, bus.RegWriteW_i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (state == RUN) begin
         if (bus.StallF_o && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (bus.FlushD_o && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign bus.Running_o  = (state == RUN);
   assign bus.StallCnt_o = stall_cnt;
   assign bus.FlushCnt_o = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand-written reset/saturation
// sequences and randomized traffic against a behavioural model.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (hif.slave)
   );

   typedef struct {
      logic       stall;
      logic       flush_d;
      logic       flush_e;
      logic [1:0] fa;
      logic [1:0] fb;
   } out_t;

   typedef struct {
      logic [1:0] res_src;
      logic [4:0] rd_e;
      logic [4:0] rs1_d;
      logic [4:0] rs2_d;
      logic [1:0] pc_src;
      logic [4:0] rs1_e;
      logic [4:0] rs2_e;
      logic [4:0] rd_m;
      logic       we_m;
      logic [4:0] rd_w;
      logic       we_w;
      logic       x_stall;
      logic       x_flush_d;
      logic       x_flush_e;
      logic [1:0] x_fa;
      logic [1:0] x_fb;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   bit m_run = 0;
   int m_scnt = 0;
   int m_fcnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (rs == 5'd0) return 2'b00;
      if (hif.RegWriteM_i && hif.RdM_i == rs) return 2'b10;
      if (hif.RegWriteW_i && hif.RdW_i == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic out_t model_out();
      out_t o;
      bit   lw, rd;
      o = '{stall: 1'b1, flush_d: 1'b1, flush_e: 1'b1, fa: 2'b00, fb: 2'b00};
      if (m_run && !rst) begin
         lw = (hif.ResultSrcE_i == 2'b01) && (hif.RdE_i != 0) &&
              (hif.RdE_i == hif.Rs1D_i || hif.RdE_i == hif.Rs2D_i);
         rd = (hif.PCSrcE_i != 0);
         o.stall   = lw && !rd;
         o.flush_d = rd;
         o.flush_e = lw || rd;
         o.fa      = m_fwd(hif.Rs1E_i);
         o.fb      = m_fwd(hif.Rs2E_i);
      end
      return o;
   endfunction

   // Check all outputs against the model, then advance one clock and update it.
   task automatic tick();
      out_t o;
      #1;
      o = model_out();
      check("StallF", hif.StallF_o, o.stall);
      check("StallD", hif.StallD_o, (m_run && !rst) ? o.stall : 1'b0);
      check("FlushD", hif.FlushD_o, o.flush_d);
      check("FlushE", hif.FlushE_o, o.flush_e);
      check("FwdA", hif.ForwardAE_o, o.fa);
      check("FwdB", hif.ForwardBE_o, o.fb);
      check("Running", hif.Running_o, m_run);
      check("StallCnt", hif.StallCnt_o, m_scnt);
      check("FlushCnt", hif.FlushCnt_o, m_fcnt);
      @(posedge clk);
      if (rst) begin
         m_run = 0; m_scnt = 0; m_fcnt = 0;
      end else if (m_run) begin
         if (o.stall)   m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
         if (o.flush_d) m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
      end else if (hif.trigger) begin
         m_run = 1;
      end
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      hif.trigger = 0; hif.Rs1D_i = 0; hif.Rs2D_i = 0; hif.Rs1E_i = 0;
      hif.Rs2E_i = 0; hif.RdE_i = 0; hif.ResultSrcE_i = 0; hif.PCSrcE_i = 0;
      hif.RdM_i = 0; hif.RegWriteM_i = 0; hif.RdW_i = 0; hif.RegWriteW_i = 0;
   endtask

   task automatic restart();
      clear_inputs();
      rst = 1; tick();
      rst = 0; hif.trigger = 1; tick();
      hif.trigger = 0;
   endtask

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{2'b01, 5'd5, 5'd0, 5'd5, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00};
      vecs[1]  = '{2'b01, 5'd0, 5'd0, 5'd5, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[2]  = '{2'b01, 5'd5, 5'd0, 5'd5, 2'b01, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
      vecs[3]  = '{2'b00, 5'd0, 5'd0, 5'd0, 2'b00, 5'd7, 5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
      vecs[4]  = '{2'b00, 5'd0, 5'd0, 5'd0, 2'b00, 5'd7, 5'd0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
      vecs[5]  = '{2'b00, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[6]  = '{2'b00, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10};
      vecs[7]  = '{2'b00, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd7, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01};
      vecs[8]  = '{2'b11, 5'd3, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[9]  = '{2'b01, 5'd3, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00};
      vecs[10] = '{2'b00, 5'd0, 5'd0, 5'd0, 2'b10, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
      vecs[11] = '{2'b00, 5'd0, 5'd0, 5'd0, 2'b00, 5'd4, 5'd9, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01};

      clear_inputs();
      @(negedge clk);

      // Reset, then IDLE held for 5 cycles without trigger
      rst = 1; tick();
      rst = 0;
      for (int i = 0; i < 5; i++) tick();
      check("idle_running", hif.Running_o, 1'b0);
      hif.trigger = 1; tick();
      hif.trigger = 0;
      #1;
      check("run_started", hif.Running_o, 1'b1);
      check("run_stallf_low", hif.StallF_o, 1'b0);

      // Directed vector table
      foreach (vecs[i]) begin
         hif.ResultSrcE_i = vecs[i].res_src; hif.RdE_i = vecs[i].rd_e;
         hif.Rs1D_i = vecs[i].rs1_d;         hif.Rs2D_i = vecs[i].rs2_d;
         hif.PCSrcE_i = vecs[i].pc_src;      hif.Rs1E_i = vecs[i].rs1_e;
         hif.Rs2E_i = vecs[i].rs2_e;         hif.RdM_i = vecs[i].rd_m;
         hif.RegWriteM_i = vecs[i].we_m;     hif.RdW_i = vecs[i].rd_w;
         hif.RegWriteW_i = vecs[i].we_w;
         #1;
         check($sformatf("v%0d_stall", i), hif.StallF_o, vecs[i].x_stall);
         check($sformatf("v%0d_stalld", i), hif.StallD_o, vecs[i].x_stall);
         check($sformatf("v%0d_flushd", i), hif.FlushD_o, vecs[i].x_flush_d);
         check($sformatf("v%0d_flushe", i), hif.FlushE_o, vecs[i].x_flush_e);
         check($sformatf("v%0d_fa", i), hif.ForwardAE_o, vecs[i].x_fa);
         check($sformatf("v%0d_fb", i), hif.ForwardBE_o, vecs[i].x_fb);
         tick();
      end
      clear_inputs();

      // Flush counter saturation at 2^CNT_W-1
      restart();
      hif.PCSrcE_i = 2'b10;
      for (int i = 0; i < CMAX + 4; i++) tick();
      check("flush_saturate", hif.FlushCnt_o, 15);
      check("stall_untouched", hif.StallCnt_o, 0);
      clear_inputs();

      // Mid-RUN reset after three load-use stalls
      restart();
      hif.ResultSrcE_i = 2'b01; hif.RdE_i = 5'd5; hif.Rs1D_i = 5'd5;
      for (int i = 0; i < 3; i++) tick();
      check("stallcnt_3", hif.StallCnt_o, 3);
      rst = 1; tick();
      rst = 0;
      for (int i = 0; i < 3; i++) tick();
      check("rst_stallcnt", hif.StallCnt_o, 0);
      check("rst_stallf", hif.StallF_o, 1'b1);
      check("rst_running", hif.Running_o, 1'b0);
      hif.trigger = 1; rst = 1; tick();
      rst = 0; hif.trigger = 0;
      check("rst_beats_trigger", hif.Running_o, 1'b0);

      // Randomized traffic with small register indices to provoke matches
      for (int i = 0; i < 600; i++) begin
         rst              = ($urandom_range(0, 59) == 0);
         hif.trigger      = ($urandom_range(0, 3) == 0);
         hif.Rs1D_i       = 5'($urandom_range(0, 3));
         hif.Rs2D_i       = 5'($urandom_range(0, 3));
         hif.Rs1E_i       = 5'($urandom_range(0, 3));
         hif.Rs2E_i       = 5'($urandom_range(0, 3));
         hif.RdE_i        = 5'($urandom_range(0, 3));
         hif.RdM_i        = 5'($urandom_range(0, 3));
         hif.RdW_i        = 5'($urandom_range(0, 3));
         hif.ResultSrcE_i = 2'($urandom_range(0, 3));
         hif.PCSrcE_i     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         hif.RegWriteM_i  = 1'($urandom_range(0, 1));
         hif.RegWriteW_i  = 1'($urandom_range(0, 1));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
